// File: rtl/cache_dados_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache (cache_dados_dm).
package cache_dados_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        RECARGA   = 2'd1,
        ESCRITA   = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    localparam int LINHAS_PADRAO   = 16;
    localparam int PALAVRAS_PADRAO = 4;

    function automatic int larg_palavra(input int palavras);
        return $clog2(palavras);
    endfunction

    function automatic int larg_off(input int palavras);
        return $clog2(palavras * 4);
    endfunction

    function automatic int larg_indice(input int linhas);
        return $clog2(linhas);
    endfunction

    function automatic int larg_tag(input int linhas, input int palavras);
        return 32 - larg_off(palavras) - larg_indice(linhas);
    endfunction

endpackage

// File: rtl/cache_dados_dm_if.sv
// Memory-side request/acknowledge bundle between the cache controller and the backing memory.
interface cache_dados_dm_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/cache_dados_ctrl.sv
// Cache FSM, memory-side handshake and refill beat counter.
// Read hit/miss counters are built only when CACHE_DADOS_STATS_EN is defined.
module cache_dados_ctrl
    import cache_dados_pkg::*;
#(
    parameter  int PALAVRAS = PALAVRAS_PADRAO,
    localparam int WSEL_W   = larg_palavra(PALAVRAS),
    localparam int OFF_W    = larg_off(PALAVRAS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic              hit_i,
    input  logic [31:2]       pal_addr_i,
    input  logic [31:0]       wdata_i,
    cache_dados_dm_if.master  mem,
    output logic              stall_o,
    output logic              fill_we_o,
    output logic [WSEL_W-1:0] fill_word_o,
    output logic              fill_last_o,
    output logic              store_we_o
`ifdef CACHE_DADOS_STATS_EN
    ,
    output logic [31:0]       acertos_o,
    output logic [31:0]       falhas_o
`endif
);

    localparam logic [WSEL_W-1:0] ULTIMO = WSEL_W'(PALAVRAS - 1);

    estado_t           estado_q;
    logic [WSEL_W-1:0] beat_q;
    logic              req_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;

    // Address/data registers carry no reset: they are only observed while req_q is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado_q <= OCIOSO;
            beat_q   <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (wr_i) begin
                        estado_q <= ESCRITA;
                        req_q    <= 1'b1;
                        we_q     <= 1'b1;
                        addr_q   <= {pal_addr_i, 2'b00};
                        wdata_q  <= wdata_i;
                    end else if (rd_i && !hit_i) begin
                        estado_q <= RECARGA;
                        req_q    <= 1'b1;
                        we_q     <= 1'b0;
                        beat_q   <= '0;
                        addr_q   <= {pal_addr_i[31:OFF_W], {(OFF_W-2){1'b0}}, 2'b00};
                    end
                end
                RECARGA: begin
                    if (mem.mem_ack) begin
                        if (beat_q == ULTIMO) begin
                            estado_q <= OCIOSO;
                            req_q    <= 1'b0;
                            beat_q   <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            addr_q <= addr_q + 32'd4;
                        end
                    end
                end
                ESCRITA: begin
                    if (mem.mem_ack) begin
                        estado_q <= CONCLUIDO;
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // CONCLUIDO lets the held store retire without re-triggering another write.
    assign stall_o = (estado_q == RECARGA) || (estado_q == ESCRITA) ||
                     ((estado_q == OCIOSO) && (wr_i || (rd_i && !hit_i)));

    assign fill_we_o   = (estado_q == RECARGA) && mem.mem_ack;
    assign fill_word_o = beat_q;
    assign fill_last_o = fill_we_o && (beat_q == ULTIMO);
    assign store_we_o  = (estado_q == OCIOSO) && wr_i && hit_i;

`ifdef CACHE_DADOS_STATS_EN
    logic        pos_recarga_q;
    logic [31:0] acertos_q;
    logic [31:0] falhas_q;
    logic        leitura;

    assign leitura = (estado_q == OCIOSO) && rd_i && !wr_i;

    // A load that finishes its own refill is counted once, as a miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_recarga_q <= 1'b0;
            acertos_q     <= '0;
            falhas_q      <= '0;
        end else begin
            pos_recarga_q <= fill_last_o;
            if (leitura && hit_i && !pos_recarga_q) acertos_q <= acertos_q + 32'd1;
            if (leitura && !hit_i)                  falhas_q  <= falhas_q + 32'd1;
        end
    end

    assign acertos_o = acertos_q;
    assign falhas_o  = falhas_q;
`endif

endmodule

// File: rtl/cache_dados_dm.sv
// Direct-mapped, write-through / no-write-allocate data cache with a single-beat memory port.
// Defining CACHE_DADOS_STATS_EN adds the cont_acertos/cont_falhas counter outputs.
module cache_dados_dm
    import cache_dados_pkg::*;
#(
    parameter int LINHAS   = LINHAS_PADRAO,
    parameter int PALAVRAS = PALAVRAS_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] endereco,
    input  logic [31:0] dado_escrita,
    output logic [31:0] dado_lido,
    output logic        stall_cache_dados,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef CACHE_DADOS_STATS_EN
    ,
    output logic [31:0] cont_acertos,
    output logic [31:0] cont_falhas
`endif
);

    localparam int WSEL_W = larg_palavra(PALAVRAS);
    localparam int OFF_W  = larg_off(PALAVRAS);
    localparam int IDX_W  = larg_indice(LINHAS);
    localparam int TAG_W  = larg_tag(LINHAS, PALAVRAS);

    cache_dados_dm_if mif ();

    assign mem_req       = mif.mem_req;
    assign mem_we        = mif.mem_we;
    assign mem_addr      = mif.mem_addr;
    assign mem_wdata     = mif.mem_wdata;
    assign mif.mem_ack   = mem_ack;
    assign mif.mem_rdata = mem_rdata;

    logic [WSEL_W-1:0] wsel;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              unused_bits;

    assign wsel        = endereco[OFF_W-1:2];
    assign idx         = endereco[OFF_W+IDX_W-1:OFF_W];
    assign tag         = endereco[31:OFF_W+IDX_W];
    assign unused_bits = ^endereco[1:0];

    logic [LINHAS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q   [LINHAS];
    logic [31:0]       dados_q [LINHAS][PALAVRAS];
    logic              hit;

    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign dado_lido = dados_q[idx][wsel];

    logic              fill_we;
    logic              fill_last;
    logic              store_we;
    logic [WSEL_W-1:0] fill_word;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    // Refill targets the line named by the outstanding memory address, not the live pipeline address.
    assign fill_idx = mif.mem_addr[OFF_W+IDX_W-1:OFF_W];
    assign fill_tag = mif.mem_addr[31:OFF_W+IDX_W];

    cache_dados_ctrl #(.PALAVRAS(PALAVRAS)) u_ctrl (
        .clk_i       (clock),
        .rst_i       (reset),
        .rd_i        (MemRead),
        .wr_i        (MemWrite),
        .hit_i       (hit),
        .pal_addr_i  (endereco[31:2]),
        .wdata_i     (dado_escrita),
        .mem         (mif),
        .stall_o     (stall_cache_dados),
        .fill_we_o   (fill_we),
        .fill_word_o (fill_word),
        .fill_last_o (fill_last),
        .store_we_o  (store_we)
`ifdef CACHE_DADOS_STATS_EN
        ,
        .acertos_o   (cont_acertos),
        .falhas_o    (cont_falhas)
`endif
    );

    // A line being refilled is invalid until its last word lands, so an abort leaves it unusable.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[fill_idx] <= fill_last;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_we) begin
            dados_q[fill_idx][fill_word] <= mem_rdata;
        end
        if (fill_last) begin
            tag_q[fill_idx] <= fill_tag;
        end
        if (store_we) begin
            dados_q[idx][wsel] <= dado_escrita;
        end
    end

endmodule

// File: doc/cache_dados_dm.md
CACHE_DADOS_DM -- requirements
Module: cache_dados_dm

Interface
REQ-001 SHALL have parameter LINHAS, default 16: number of direct-mapped lines; power of 2, >=2.
REQ-002 SHALL have parameter PALAVRAS, default 4: 32-bit words per line; power of 2, >=2.
REQ-003 SHALL have port clock  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high.
REQ-005 SHALL have port MemRead  in  1: pipeline load request.
REQ-006 SHALL have port MemWrite  in  1: pipeline store request (full word).
REQ-007 SHALL have port endereco  in  32: byte address; bits [1:0] ignored.
REQ-008 SHALL have port dado_escrita  in  32: store data.
REQ-009 SHALL have port dado_lido  out  32: load data, valid when MemRead && !stall_cache_dados.
REQ-010 SHALL have port stall_cache_dados  out  1: freeze pipeline.
REQ-011 SHALL have port mem_req  out  1: memory-side request, held until mem_ack.
REQ-012 SHALL have port mem_we  out  1: 1 = write beat, 0 = read beat.
REQ-013 SHALL have port mem_addr  out  32: word-aligned memory address.
REQ-014 SHALL have port mem_wdata  out  32: write beat data.
REQ-015 SHALL have port mem_ack  in  1: beat complete; mem_rdata valid same cycle.
REQ-016 SHALL have port mem_rdata  in  32: read beat data.

Function
REQ-017 SHALL split address: word select = endereco[OFF-1:2], index = next log2(LINHAS) bits, tag = remaining upper bits, OFF = log2(PALAVRAS*4).
REQ-018 SHALL compute hit = valid[index] && tag[index]==address tag, combinationally.
REQ-019 SHALL use FSM states OCIOSO, RECARGA, ESCRITA, CONCLUIDO.
REQ-020 SHALL deliver read hit in OCIOSO with zero-cycle latency and stall_cache_dados=0.
REQ-021 SHALL, on read miss in OCIOSO, assert stall combinationally and enter RECARGA next edge.
REQ-022 SHALL in RECARGA issue PALAVRAS read beats at line base + 4*k, k=0..PALAVRAS-1, advancing k on each mem_ack.
REQ-023 SHALL write each returned word into the line; on final ack write tag, set valid, return to OCIOSO; hit resolves next cycle.
REQ-024 SHALL treat stores as write-through, no-write-allocate: in OCIOSO a store stalls and enters ESCRITA; single write beat of dado_escrita to endereco.
REQ-025 SHALL update the cached word on a store hit (hit evaluated on OCIOSO entry cycle); on miss leave the array untouched.
REQ-026 SHALL on ESCRITA mem_ack enter CONCLUIDO; CONCLUIDO holds stall=0 for exactly one cycle, then OCIOSO.
REQ-027 SHALL hold stall_cache_dados=1 throughout RECARGA and ESCRITA.
REQ-028 SHALL give MemWrite priority when MemRead and MemWrite are both high.
REQ-029 SHALL hold mem_addr, mem_we, mem_wdata stable while mem_req=1 and mem_ack=0.
REQ-030 SHALL not stall when MemRead=MemWrite=0 in OCIOSO.

Reset
REQ-031 SHALL on reset clear all valid bits, FSM to OCIOSO, beat counter to 0, mem_req=0, mem_we=0, stall=0; tag/data arrays need no reset.
REQ-032 SHALL on reset mid-RECARGA or mid-ESCRITA abort immediately; partially refilled line stays invalid.

Configuration
REQ-033 SHALL, with CACHE_DADOS_STATS_EN defined, add outputs cont_acertos and cont_falhas (32 bits, wrapping), counting read hits delivered and read misses entering RECARGA; cleared by reset.
REQ-034 SHALL, without CACHE_DADOS_STATS_EN, omit those ports and counters entirely.

Structure
REQ-035 SHALL place FSM state enum, default LINHAS/PALAVRAS and derived width functions in package cache_dados_pkg.
REQ-036 SHALL implement memory-side handshake and beat counter in sub-module cache_dados_ctrl; arrays stay in top.

Verification
REQ-037 Reset, then MemRead at 0x0000_1234 -> stall=1, beats at 0x1230/0x1234/0x1238/0x123C, index 3 valid with tag 0x000012, then dado_lido = word 1, stall=0.
REQ-038 Repeat read 0x0000_1238 after refill -> hit, stall=0 same cycle, no mem_req.
REQ-039 Store 0xDEADBEEF to 0x0000_1234 (hit) -> one write beat, CONCLUIDO one cycle stall=0; later read returns 0xDEADBEEF without refill.
REQ-040 Store to 0x0000_5600 (miss) -> one write beat, index 0 remains invalid; read 0x0000_5600 refills.
REQ-041 Assert reset after second refill ack -> mem_req=0 next cycle, line invalid, re-read refills all 4 beats.
REQ-042 With CACHE_DADOS_STATS_EN: 1 miss + 3 hits -> cont_falhas=1, cont_acertos=3; mem_ack delayed 5 cycles per beat -> stall held, addresses stable.
